uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one uart transmitter (2..8).
REQ-002 Parameter BUSY_TIMEOUT, default 4, max clk cycles to wait for uart is_transmitting to rise after a transmit pulse.
REQ-003 Port clk  input  1  master clock; single clock domain.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-006 Port req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 Port req_lock  input  NUM_REQ  per-requester keep-grant flag, qualified by accept.
REQ-008 Port req_ready  output  NUM_REQ  one-hot accept strobe; a byte transfers when valid and ready are both high.
REQ-009 Port uart_transmit  output  1  one-cycle start pulse to the uart transmit input.
REQ-010 Port uart_tx_byte  output  8  registered byte driven to the uart tx_byte input.
REQ-011 Port uart_is_transmitting  input  1  uart transmitter-busy status.
REQ-012 Port grant  output  NUM_REQ  one-hot owner of the byte in flight; zero when idle.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port timeout_err  output  1  one-cycle pulse when BUSY_TIMEOUT expires.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE with any req_valid: pick winner round-robin, searching from (last_winner+1) mod NUM_REQ; drive req_ready[winner] combinationally that cycle; latch its byte into uart_tx_byte; set grant; go to ISSUE.
REQ-017 req_ready is zero in all states other than IDLE; at most one bit set.
REQ-018 ISSUE: uart_transmit=1 for exactly one cycle; clear timeout counter; go to WAIT_BUSY.
REQ-019 Latency: valid seen in IDLE at cycle N gives ready at N and uart_transmit at N+1.
REQ-020 WAIT_BUSY: is_transmitting high goes to WAIT_DONE; otherwise counter increments; on count==BUSY_TIMEOUT, pulse timeout_err, clear grant, go to IDLE.
REQ-021 WAIT_DONE: is_transmitting low goes to IDLE and clears grant; the next acceptance can occur that same IDLE cycle.
REQ-022 Round-robin pointer updates only on accept; last_winner resets to NUM_REQ-1, so requester 0 has first priority.
REQ-023 uart_tx_byte holds its value from accept until the next accept.
REQ-024 req_valid changes outside IDLE are ignored; requesters are never starved; worst-case wait is NUM_REQ-1 bytes.

Reset
REQ-025 On rst: state IDLE, grant=0, req_ready=0, uart_transmit=0, uart_tx_byte=0, busy=0, timeout_err=0, counter=0, last_winner=NUM_REQ-1, lock owner cleared.
REQ-026 rst asserted mid-byte aborts the sequence without a further uart_transmit pulse; the uart is reset by the same rst.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN defined: accepting a byte with req_lock[i]=1 makes i lock owner; in IDLE only the owner is eligible; accepting from the owner with req_lock=0 releases; timeout_err also releases.
REQ-028 UART_ARB_LOCK_EN undefined: req_lock is ignored, the port remains, pure round-robin.

Structure
REQ-029 Shared package uart_pkg holds the FSM state encoding and the default BUSY_TIMEOUT constant.
REQ-030 Sub-module rr_arbiter (request vector plus pointer in, one-hot grant out, combinational) is natural and is reused.

Verification
REQ-031 Single request: valid[0]=1, data 0x55 -> ready[0] at cycle N, transmit at N+1 with tx_byte=0x55; busy drops one cycle after is_transmitting falls.
REQ-032 All four valid constantly, bytes 0xA0..0xA3 -> uart bytes sent in order 0xA0,0xA1,0xA2,0xA3,0xA0; exactly one transmit pulse per byte.
REQ-033 Stubbed uart never raises is_transmitting -> timeout_err pulses 4 cycles after entering WAIT_BUSY; FSM returns to IDLE and serves the next requester.
REQ-034 With UART_ARB_LOCK_EN, req 2 sends 3 bytes with lock=1,1,0 while req 0 and req 1 stay valid -> all 3 req-2 bytes are contiguous, then req 0 is served.
REQ-035 rst pulsed during WAIT_DONE -> all outputs reach reset values the next cycle; next grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit arbiter: FSM encoding and default timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int unsigned DEFAULT_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from (ptr+1) mod N, returns one-hot and index.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int unsigned cand;
  logic [IW-1:0] cand_idx;
  logic found;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = cand[IW-1:0];
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ byte requesters onto one uart transmitter.
// Define UART_ARB_LOCK_EN to let a requester hold the grant across bytes via req_lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_transmit,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_is_transmitting,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        last_winner, win_idx;
  logic [NUM_REQ-1:0]   elig, win_oh;
  logic [CW-1:0]        cnt;
  logic                 accept, tmo;

`ifdef UART_ARB_LOCK_EN
  logic          lock_act;
  logic [IW-1:0] lock_own;

  assign elig = lock_act ? (req_valid & (NUM_REQ'(1) << lock_own)) : req_valid;

  // Only the owner can be accepted while locked, so any accept with lock=0 releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_act <= 1'b0;
      lock_own <= '0;
    end else if (tmo) begin
      lock_act <= 1'b0;
    end else if (accept) begin
      lock_act <= req_lock[win_idx];
      lock_own <= win_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign elig        = req_valid;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (elig),
    .ptr     (last_winner),
    .gnt     (win_oh),
    .gnt_idx (win_idx)
  );

  assign accept        = (state == IDLE) && (|win_oh);
  assign req_ready     = (state == IDLE) ? win_oh : '0;
  assign uart_transmit = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign timeout_err   = tmo;

  always_comb begin
    state_nxt = state;
    tmo       = 1'b0;
    case (state)
      IDLE:      if (accept) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_is_transmitting) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT)) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (!uart_is_transmitting) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      uart_tx_byte <= '0;
      cnt          <= '0;
      last_winner  <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant        <= win_oh;
        uart_tx_byte <= req_data[8*win_idx +: 8];
        last_winner  <= win_idx;
      end else if (tmo || (state == WAIT_DONE && !uart_is_transmitting)) begin
        grant <= '0;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT_BUSY && !uart_is_transmitting && !tmo)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus round-robin and lock sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        uart_is_transmitting;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  logic        stub_en;
  logic        drv_is_tx;
  logic [1:0]  stub_cnt;
  logic [7:0]  sent[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_data             (req_data),
    .req_lock             (req_lock),
    .req_ready            (req_ready),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .grant                (grant),
    .busy                 (busy),
    .timeout_err          (timeout_err)
  );

  // Stub uart: busy for three cycles after each transmit pulse.
  always @(posedge clk) begin
    if (rst) stub_cnt <= 2'd0;
    else if (uart_transmit) stub_cnt <= 2'd3;
    else if (stub_cnt != 2'd0) stub_cnt <= stub_cnt - 2'd1;
    if (!rst && uart_transmit) sent.push_back(uart_tx_byte);
  end

  assign uart_is_transmitting = stub_en ? (stub_cnt != 2'd0) : drv_is_tx;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       is_tx;
    logic [3:0] e_ready;
    logic       e_tx;
    logic [7:0] e_byte;
    logic [3:0] e_grant;
    logic       e_busy;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic t, input logic [3:0] er,
                     input logic etx, input logic [7:0] eb, input logic [3:0] eg,
                     input logic ebs, input logic eto);
    vec_t x;
    x.rst = r; x.valid = v; x.is_tx = t; x.e_ready = er; x.e_tx = etx;
    x.e_byte = eb; x.e_grant = eg; x.e_busy = ebs; x.e_to = eto;
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n2;
    stub_en   = 1'b0;
    drv_is_tx = 1'b0;
    req_data  = 32'hA3A2_A155;

    //  rst valid  istx   ready  tx  byte   grant  busy to
    add(0, 4'b0000, 0,  4'b0000, 0, 8'h00, 4'b0000, 0, 0); // reset state
    add(0, 4'b0001, 0,  4'b0001, 0, 8'h00, 4'b0000, 0, 0); // accept req0
    add(0, 4'b0000, 0,  4'b0000, 1, 8'h55, 4'b0001, 1, 0); // ISSUE
    add(0, 4'b0000, 1,  4'b0000, 0, 8'h55, 4'b0001, 1, 0); // WAIT_BUSY
    add(0, 4'b0000, 1,  4'b0000, 0, 8'h55, 4'b0001, 1, 0); // WAIT_DONE
    add(0, 4'b0000, 0,  4'b0000, 0, 8'h55, 4'b0001, 1, 0); // uart falls
    add(0, 4'b0000, 0,  4'b0000, 0, 8'h55, 4'b0000, 0, 0); // idle, byte held
    add(0, 4'b0011, 0,  4'b0010, 0, 8'h55, 4'b0000, 0, 0); // rr picks req1
    add(0, 4'b0000, 0,  4'b0000, 1, 8'hA1, 4'b0010, 1, 0);
    add(0, 4'b0000, 0,  4'b0000, 0, 8'hA1, 4'b0010, 1, 0); // WAIT_BUSY cnt0
    add(0, 4'b0000, 0,  4'b0000, 0, 8'hA1, 4'b0010, 1, 0);
    add(0, 4'b0000, 0,  4'b0000, 0, 8'hA1, 4'b0010, 1, 0);
    add(0, 4'b0000, 0,  4'b0000, 0, 8'hA1, 4'b0010, 1, 0);
    add(0, 4'b0000, 0,  4'b0000, 0, 8'hA1, 4'b0010, 1, 1); // timeout
    add(0, 4'b0011, 0,  4'b0001, 0, 8'hA1, 4'b0000, 0, 0); // wraps to req0
    add(0, 4'b0000, 0,  4'b0000, 1, 8'h55, 4'b0001, 1, 0);
    add(0, 4'b0000, 1,  4'b0000, 0, 8'h55, 4'b0001, 1, 0);
    add(1, 4'b0000, 1,  4'b0000, 0, 8'h55, 4'b0001, 1, 0); // rst in WAIT_DONE
    add(0, 4'b0000, 0,  4'b0000, 0, 8'h00, 4'b0000, 0, 0); // reset values
    add(0, 4'b1111, 0,  4'b0001, 0, 8'h00, 4'b0000, 0, 0); // pointer reset
    add(0, 4'b0000, 0,  4'b0000, 1, 8'h55, 4'b0001, 1, 0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].valid;
      drv_is_tx = vecs[i].is_tx;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_transmit", i), 32'(uart_transmit), 32'(vecs[i].e_tx));
      chk($sformatf("v%0d_tx_byte", i), 32'(uart_tx_byte), 32'(vecs[i].e_byte));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_timeout", i), 32'(timeout_err), 32'(vecs[i].e_to));
      @(posedge clk);
      #1;
    end

    // All four requesters continuously valid: strict rotation.
    stub_en  = 1'b1;
    req_data = 32'hA3A2_A1A0;
    do_reset();
    sent.delete();
    req_valid = 4'b1111;
    for (int c = 0; c < 200 && sent.size() < 5; c++) @(posedge clk);
    #1;
    req_valid = '0;
    chk("rr_byte_count", 32'(sent.size()), 32'd5);
    for (int i = 0; i < 5 && i < sent.size(); i++)
      chk($sformatf("rr_byte%0d", i), 32'(sent[i]), 32'(8'hA0 + 8'(i % 4)));

    // Requester 2 sends three bytes with lock 1,1,0 while 0 and 1 wait.
    do_reset();
    sent.delete();
    n2 = 0;
    for (int c = 0; c < 300 && sent.size() < 4; c++) begin
      req_valid = {1'b0, n2 < 3, n2 >= 1, n2 >= 1};
      req_lock  = {1'b0, n2 < 2, 2'b00};
      #1;
      if (req_ready[2]) n2++;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    chk("lock_byte_count", 32'(sent.size()), 32'd4);
    begin
      logic [7:0] exp_seq[4];
`ifdef UART_ARB_LOCK_EN
      exp_seq = '{8'hA2, 8'hA2, 8'hA2, 8'hA0};
`else
      exp_seq = '{8'hA2, 8'hA0, 8'hA1, 8'hA2};
`endif
      for (int i = 0; i < 4 && i < sent.size(); i++)
        chk($sformatf("lock_byte%0d", i), 32'(sent[i]), 32'(exp_seq[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
